// File: rtl/usrp2puf.sv
// usrp2puf: 5:4 decimating linear-interpolation resampler for complex IQ
// AXI-Stream samples. Every 5 input beats yield 4 outputs at input positions
// 0, 1.25, 2.5 and 3.75. Two-stage multiply / sum-round pipeline, throughput
// one beat per cycle, backpressure stalls the whole pipeline.
module usrp2puf #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_tvalid,
  input  logic                    in_tlast,
  output logic                    in_tready,
  input  logic [2*DATA_WIDTH-1:0] in_tdata,
  output logic                    out_tvalid,
  output logic                    out_tlast,
  input  logic                    out_tready,
  output logic [2*DATA_WIDTH-1:0] out_tdata,
  output logic [2:0]              phase
);

  localparam int unsigned SW = DATA_WIDTH + FRAC_BITS + 3;

  // Interpolation weights; the two weights of every phase sum to unity, so
  // the rounded result always fits DATA_WIDTH without saturation.
  localparam logic signed [SW-1:0] W_ONE  = SW'(1) << FRAC_BITS;
  localparam logic signed [SW-1:0] W_HALF = W_ONE >>> 1;
  localparam logic signed [SW-1:0] W_QTR  = W_ONE >>> 2;
  localparam logic signed [SW-1:0] W_3QTR = W_HALF + W_QTR;

  typedef enum logic [2:0] {
    PH0 = 3'd0,
    PH1 = 3'd1,
    PH2 = 3'd2,
    PH3 = 3'd3,
    PH4 = 3'd4
  } phase_e;

  phase_e phase_q, phase_d;

  logic en, accept, emit;
  logic signed [SW-1:0] wa, wb;

  logic signed [DATA_WIDTH-1:0] cur_re, cur_im;
  logic signed [DATA_WIDTH-1:0] prev_re_q, prev_im_q;

  logic signed [SW-1:0] pa_re_d, pb_re_d, pa_im_d, pb_im_d;
  logic signed [SW-1:0] pa_re_q, pb_re_q, pa_im_q, pb_im_q;
  logic                 s1_vld_q, s1_last_q;

  logic signed [SW-1:0] sum_re, sum_im, rnd_re, rnd_im;
  logic [2*DATA_WIDTH-1:0] out_data_d;

  logic                    out_vld_q, out_last_q;
  logic [2*DATA_WIDTH-1:0] out_data_q;

  logic unused_bits;

  // Pipeline advances whenever the output register is empty or being drained.
  assign en        = ~out_vld_q | out_tready;
  assign in_tready = en;
  assign accept    = in_tvalid & en;

  assign cur_re = in_tdata[2*DATA_WIDTH-1:DATA_WIDTH];
  assign cur_im = in_tdata[DATA_WIDTH-1:0];

  // Per-phase weight selection, output emission and phase sequencing.
  always_comb begin
    wa      = '0;
    wb      = W_ONE;
    emit    = 1'b1;
    phase_d = phase_q;
    unique case (phase_q)
      PH0: ;
      // A packet ending on phase 1 would otherwise lose its tlast: flush cur.
      PH1: emit = in_tlast;
      PH2: begin wa = W_3QTR; wb = W_QTR;  end
      PH3: begin wa = W_HALF; wb = W_HALF; end
      PH4: begin wa = W_QTR;  wb = W_3QTR; end
      default: ;
    endcase
    if (accept) begin
      phase_d = (in_tlast || phase_q == PH4) ? PH0 : phase_e'(phase_q + 3'd1);
    end
  end

  assign pa_re_d = wa * SW'(prev_re_q);
  assign pb_re_d = wb * SW'(cur_re);
  assign pa_im_d = wa * SW'(prev_im_q);
  assign pb_im_d = wb * SW'(cur_im);

  // Round half up, then drop the fractional bits.
  assign sum_re = pa_re_q + pb_re_q + W_HALF;
  assign sum_im = pa_im_q + pb_im_q + W_HALF;
  assign rnd_re = sum_re >>> FRAC_BITS;
  assign rnd_im = sum_im >>> FRAC_BITS;
  assign out_data_d = {rnd_re[DATA_WIDTH-1:0], rnd_im[DATA_WIDTH-1:0]};
  assign unused_bits = ^{rnd_re[SW-1:DATA_WIDTH], rnd_im[SW-1:DATA_WIDTH]};

  // Phase counter and previous-sample register move on accepted beats only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q   <= PH0;
      prev_re_q <= '0;
      prev_im_q <= '0;
    end else begin
      phase_q <= phase_d;
      if (accept) begin
        prev_re_q <= cur_re;
        prev_im_q <= cur_im;
      end
    end
  end

  // Stage 1: register weighted products with valid/tlast.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      pa_re_q   <= '0;
      pb_re_q   <= '0;
      pa_im_q   <= '0;
      pb_im_q   <= '0;
    end else if (en) begin
      s1_vld_q  <= accept & emit;
      s1_last_q <= accept & in_tlast;
      pa_re_q   <= pa_re_d;
      pb_re_q   <= pb_re_d;
      pa_im_q   <= pa_im_d;
      pb_im_q   <= pb_im_d;
    end
  end

  // Stage 2: output register; data only reloads on a valid stage-1 beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
    end else if (en) begin
      out_vld_q  <= s1_vld_q;
      out_last_q <= s1_vld_q & s1_last_q;
      if (s1_vld_q) begin
        out_data_q <= out_data_d;
      end
    end
  end

  assign out_tvalid = out_vld_q;
  assign out_tlast  = out_last_q;
  assign out_tdata  = out_data_q;
  assign phase      = phase_q;

endmodule
